branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Consumer end of the 64-bit ALU interface in the pipelined RISC-V core; sits in the EX stage directly after the ALU.
- Takes the ALU outputs (Result, Zero, Great) together with the ID/EX branch information and resolves conditional branches.
- Registers the outcome into the EX/MEM boundary, drives a one-cycle PC redirect, and squashes the wrong-path instructions behind a taken branch.

Parameters:
- XLEN, 64, datapath width; must match the ALU.
- FLUSH_DEPTH, 2, number of younger instructions squashed after a taken branch (range 1–7).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- stall  input  1  pipeline hold; when high, all state and outputs hold.
- ex_valid  input  1  ID/EX slot holds a live instruction.
- ex_is_branch  input  1  instruction is a conditional branch (B-type).
- ex_funct3  input  3  000 beq, 001 bne, 100 blt, 101 bge; other codes never taken.
- ex_pc  input  XLEN  PC of the EX instruction.
- ex_imm  input  XLEN  sign-extended branch offset.
- alu_result  input  XLEN  ALU Result (a−b for branches).
- alu_zero  input  1  ALU Zero.
- alu_great  input  1  ALU Great (Result ≠ 0, unsigned).
- mem_valid  output  1  registered: EX/MEM slot is live.
- mem_result  output  XLEN  registered ALU result.
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  output  XLEN  branch target, ex_pc + ex_imm, modulo 2^XLEN.
- flush  output  1  high while the unit is squashing the wrong path.
- branch_taken  output  1  registered taken flag for the branch in EX/MEM.

Behaviour:
- **Reset:** asynchronous, active-low. All outputs go to 0 and the FSM goes to IDLE. Reset asserted mid-SQUASH aborts the squash; counter clears to 0.
- **Taken condition** (evaluated only when ex_valid & ex_is_branch & the slot is not being squashed):
  - beq: taken = alu_zero.
  - bne: taken = alu_great.
  - blt: taken = alu_result[XLEN-1].
  - bge: taken = ~alu_result[XLEN-1].
  - Signed overflow of a−b is ignored (this is the defined behaviour of the unit).
- **Latency:** 1 cycle. EX inputs sampled at edge N appear on mem_* and branch_taken after edge N, and so does redirect_valid.
- **mem_valid** = ex_valid & ~squash_now. mem_result = alu_result, loaded unconditionally when not stalled.
- **FSM states:** IDLE, SQUASH, with a 3-bit counter cnt.
  - IDLE: a taken branch makes redirect_valid=1, redirect_pc=target for exactly 1 cycle; go to SQUASH with cnt=FLUSH_DEPTH; flush=1.
  - SQUASH: each unstalled cycle, the incoming EX slot is dropped (mem_valid=0, no branch evaluation) and cnt decrements. When cnt reaches 1 and is consumed, return to IDLE; flush=0 from the next cycle.
  - A branch arriving during SQUASH is wrong-path: it is never taken and never redirects.
- **Stall:** when stall=1, no register updates, cnt holds, and the FSM holds. redirect_valid is forced to 0 during stall and re-asserted on the first unstalled cycle if a redirect is still pending, so fetch sees exactly one accepted pulse.
- **Simultaneous events:**
  - stall and a taken branch in the same cycle: the branch is evaluated on the first cycle stall=0.
  - reset_n low overrides everything.
- **Wrap-around:** target addition wraps silently. A target equal to ex_pc (imm=0) is still a taken branch.
- **Non-branches:** ex_valid & ~ex_is_branch passes through with branch_taken=0.
- **Invalid funct3** (010, 011, 110, 111): not taken.

Test Plan:
- **Reset mid-squash:** beq taken, then reset_n=0 for 1 cycle during SQUASH -> all outputs 0 immediately; next non-branch passes with mem_valid=1.
- **beq taken:** ex_pc=0x1000, ex_imm=0x40, alu_zero=1 -> next cycle redirect_valid=1, redirect_pc=0x1040, branch_taken=1; the following 2 EX slots produce mem_valid=0 and flush=1; the 3rd slot has mem_valid=1, flush=0.
- **blt not taken:** alu_result=0x0000_0000_0000_0005 -> redirect_valid=0, mem_valid=1, mem_result=5, no squash.
- **bge with overflow:** alu_result=0x8000_0000_0000_0000 -> not taken; redirect_valid stays 0.
- **Wrong-path branch during SQUASH:** bne with alu_great=1 arriving in the squash window -> no second redirect; squash ends after exactly FLUSH_DEPTH slots.
- **Stall during pending redirect:** taken branch with stall=1 for 3 cycles, then 0 -> exactly one redirect_valid pulse, on the first unstalled cycle. Also ex_pc=0xFFFF_FFFF_FFFF_FFF0, ex_imm=0x20 -> redirect_pc=0x10.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates B-type conditions from the ALU flags, registers
// the EX/MEM slot, issues a one-cycle PC redirect and squashes the wrong path behind it.
module branch_resolve_unit #(
   parameter int XLEN        = 64,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero,
   input  logic            alu_great,
   output logic            mem_valid,
   output logic [XLEN-1:0] mem_result,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            branch_taken,
   output logic            dbg_state,
   output logic [2:0]      dbg_cnt
);

   typedef enum logic {
      IDLE   = 1'b0,
      SQUASH = 1'b1
   } state_e;

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              squash_now;
   logic              cond_met;
   logic              taken_now;

   logic              mem_valid_q;
   logic [XLEN-1:0]   mem_result_q;
   logic              branch_taken_q;
   logic              redirect_pend_q;
   logic [XLEN-1:0]   redirect_pc_q;

   // Signed overflow of a-b is deliberately ignored: blt/bge look only at the sign bit.
   always_comb begin
      cond_met = 1'b0;
      case (ex_funct3)
         3'b000:  cond_met = alu_zero;
         3'b001:  cond_met = alu_great;
         3'b100:  cond_met = alu_result[XLEN-1];
         3'b101:  cond_met = ~alu_result[XLEN-1];
         default: cond_met = 1'b0;
      endcase
   end

   assign taken_now = ex_valid & ex_is_branch & ~squash_now & cond_met;

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM: next state; a stalled cycle holds both state and counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!stall) begin
         case (state_q)
            IDLE: begin
               if (taken_now) begin
                  state_d = SQUASH;
                  cnt_d   = FLUSH_INIT;
               end
            end
            SQUASH: begin
               if (cnt_q <= 3'd1) begin
                  state_d = IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 3'd0;
            end
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      squash_now = (state_q == SQUASH);
      flush      = squash_now;
      dbg_state  = squash_now;
      dbg_cnt    = cnt_q;
   end

   // EX/MEM slot; the redirect stays pending until a cycle with stall low consumes it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_valid_q     <= 1'b0;
         mem_result_q    <= '0;
         branch_taken_q  <= 1'b0;
         redirect_pend_q <= 1'b0;
         redirect_pc_q   <= '0;
      end else if (!stall) begin
         mem_valid_q     <= ex_valid & ~squash_now;
         mem_result_q    <= alu_result;
         branch_taken_q  <= taken_now;
         redirect_pend_q <= taken_now;
         if (taken_now) begin
            redirect_pc_q <= ex_pc + ex_imm;
         end
      end
   end

   assign mem_valid      = mem_valid_q;
   assign mem_result     = mem_result_q;
   assign branch_taken   = branch_taken_q;
   assign redirect_pc    = redirect_pc_q;
   assign redirect_valid = redirect_pend_q & ~stall;

endmodule
